// File: rtl/back_propagation_scheduler_pkg.sv
// rtl/back_propagation_scheduler_pkg.sv - shared layer codes, FSM encoding and node counts
package back_propagation_scheduler_pkg;

    localparam logic [1:0] LAYER_INPUT = 2'd0;
    localparam logic [1:0] LAYER_H1    = 2'd1;
    localparam logic [1:0] LAYER_H2    = 2'd2;
    localparam logic [1:0] LAYER_OUT   = 2'd3;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_STREAM   = 3'd1;
    localparam logic [2:0] ST_WAIT_ERR = 3'd2;
    localparam logic [2:0] ST_DONE     = 3'd3;
    localparam logic [2:0] ST_TIMEOUT  = 3'd4;

    localparam int unsigned N_INPUT_NODES = 2;
    localparam int unsigned N_H1_NODES    = 32;
    localparam int unsigned N_H2_NODES    = 32;
    localparam int unsigned N_OUT_NODES   = 3;

endpackage

// File: rtl/bp_weight_server.sv
// rtl/bp_weight_server.sv - weight request to RAM read to response pipeline with bad-request flag
module bp_weight_server
    import back_propagation_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH           = 32,
    parameter int LAYER_WIDTH          = 2,
    parameter int WEIGHT_COUNTER_WIDTH = 11
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_clear,
    input  logic                            i_req_valid,
    input  logic [LAYER_WIDTH-1:0]          i_req_layer,
    input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_req_addr,
    output logic                            o_wram_rd_en,
    output logic [LAYER_WIDTH-1:0]          o_wram_rd_layer,
    output logic [WEIGHT_COUNTER_WIDTH-1:0] o_wram_rd_addr,
    input  logic [DATA_WIDTH-1:0]           i_wram_rd_data,
    output logic                            o_weight_valid,
    output logic [LAYER_WIDTH-1:0]          o_weight_layer,
    output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
    output logic [DATA_WIDTH-1:0]           o_weight,
    output logic                            o_bad_request
);

    logic                            req_ok;
    logic                            req_bad;
    logic                            weight_valid_d, weight_valid_q;
    logic [LAYER_WIDTH-1:0]          weight_layer_d, weight_layer_q;
    logic [WEIGHT_COUNTER_WIDTH-1:0] weight_addr_d,  weight_addr_q;
    logic                            bad_d, bad_q;

    // Only hidden-2 and output layers own weight matrices; anything else is a datapath bug.
    always_comb begin
        req_ok  = i_req_valid && ((i_req_layer == LAYER_WIDTH'(LAYER_H2)) ||
                                  (i_req_layer == LAYER_WIDTH'(LAYER_OUT)));
        req_bad = i_req_valid && !req_ok;
        weight_valid_d = req_ok;
        weight_layer_d = req_ok ? i_req_layer : '0;
        weight_addr_d  = req_ok ? i_req_addr  : '0;
        bad_d = req_bad || (bad_q && !i_clear);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_valid_q <= 1'b0;
            weight_layer_q <= '0;
            weight_addr_q  <= '0;
            bad_q          <= 1'b0;
        end else begin
            weight_valid_q <= weight_valid_d;
            weight_layer_q <= weight_layer_d;
            weight_addr_q  <= weight_addr_d;
            bad_q          <= bad_d;
        end
    end

    assign o_wram_rd_en    = req_ok;
    assign o_wram_rd_layer = weight_layer_d;
    assign o_wram_rd_addr  = weight_addr_d;
    assign o_weight_valid  = weight_valid_q;
    assign o_weight_layer  = weight_layer_q;
    assign o_weight_addr   = weight_addr_q;
    assign o_weight        = weight_valid_q ? i_wram_rd_data : '0;
    assign o_bad_request   = bad_q;

endmodule

// File: rtl/back_propagation_scheduler.sv
// rtl/back_propagation_scheduler.sv - streams layer data into back_propagation and tracks error-word completion
module back_propagation_scheduler
    import back_propagation_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH                    = 32,
    parameter int LAYER_WIDTH                   = 2,
    parameter int NUMBER_OF_INPUT_NODE          = N_INPUT_NODES,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = N_H1_NODES,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = N_H2_NODES,
    parameter int NUMBER_OF_OUTPUT_NODE         = N_OUT_NODES,
    parameter int WEIGHT_COUNTER_WIDTH          = 11,
    parameter int NUMBER_OF_ERRORS              = 1155,
    parameter int TIMEOUT_CYCLES                = 6000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_start,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_timeout,
    output logic                            o_bad_request,
    output logic                            o_data_rd_en,
    output logic [LAYER_WIDTH-1:0]          o_data_rd_layer,
    output logic [4:0]                      o_data_rd_addr,
    input  logic [DATA_WIDTH-1:0]           i_data_rd_data,
    output logic                            o_exp_rd_en,
    output logic [1:0]                      o_exp_rd_addr,
    input  logic [DATA_WIDTH-1:0]           i_exp_rd_data,
    output logic                            o_wram_rd_en,
    output logic [LAYER_WIDTH-1:0]          o_wram_rd_layer,
    output logic [WEIGHT_COUNTER_WIDTH-1:0] o_wram_rd_addr,
    input  logic [DATA_WIDTH-1:0]           i_wram_rd_data,
    output logic                            o_data_valid,
    output logic [LAYER_WIDTH-1:0]          o_data_layer,
    output logic [4:0]                      o_data_addr,
    output logic [DATA_WIDTH-1:0]           o_data,
    output logic                            o_data_expected_valid,
    output logic [1:0]                      o_data_expected_addr,
    output logic [DATA_WIDTH-1:0]           o_data_expected,
    input  logic                            i_weight_valid_request,
    input  logic [LAYER_WIDTH-1:0]          i_weight_layer_request,
    input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_weight_addr_request,
    output logic                            o_weight_valid,
    output logic [LAYER_WIDTH-1:0]          o_weight_layer,
    output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
    output logic [DATA_WIDTH-1:0]           o_weight,
    input  logic                            i_error_valid
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WEIGHT_COUNTER_WIDTH-1:0] ERR_TARGET = WEIGHT_COUNTER_WIDTH'(NUMBER_OF_ERRORS);

    logic [2:0]                      state_d, state_q;
    logic [LAYER_WIDTH-1:0]          rd_layer_d, rd_layer_q;
    logic [4:0]                      rd_addr_d, rd_addr_q;
    logic [WEIGHT_COUNTER_WIDTH-1:0] err_cnt_d, err_cnt_q;
    logic [WD_W-1:0]                 wd_d, wd_q;
    logic                            data_valid_d, data_valid_q;
    logic [LAYER_WIDTH-1:0]          data_layer_d, data_layer_q;
    logic [4:0]                      data_addr_d, data_addr_q;
    logic                            exp_valid_d, exp_valid_q;
    logic [1:0]                      exp_addr_d, exp_addr_q;
    logic                            start_accept;
    logic                            err_inc;
    logic                            err_reached;
    logic [4:0]                      last_addr;
    logic                            stream_last;

    always_comb begin
        state_d    = state_q;
        rd_layer_d = rd_layer_q;
        rd_addr_d  = rd_addr_q;
        wd_d       = '0;

        start_accept = (state_q == ST_IDLE) && i_start;
        err_inc      = i_error_valid && (err_cnt_q != ERR_TARGET) &&
                       ((state_q == ST_STREAM) || (state_q == ST_WAIT_ERR));
        err_cnt_d    = start_accept ? '0 : err_cnt_q + WEIGHT_COUNTER_WIDTH'(err_inc);
        err_reached  = (err_cnt_d == ERR_TARGET);

        case (rd_layer_q)
            LAYER_WIDTH'(LAYER_INPUT): last_addr = 5'(NUMBER_OF_INPUT_NODE - 1);
            LAYER_WIDTH'(LAYER_H1):    last_addr = 5'(NUMBER_OF_HIDDEN_NODE_LAYER_1 - 1);
            LAYER_WIDTH'(LAYER_H2):    last_addr = 5'(NUMBER_OF_HIDDEN_NODE_LAYER_2 - 1);
            default:                   last_addr = 5'(NUMBER_OF_OUTPUT_NODE - 1);
        endcase
        stream_last = (rd_layer_q == LAYER_WIDTH'(LAYER_OUT)) && (rd_addr_q == last_addr);

        case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    state_d    = ST_STREAM;
                    rd_layer_d = '0;
                    rd_addr_d  = '0;
                end
            end
            ST_STREAM: begin
                if (stream_last) begin
                    // Errors may all arrive before the stream finishes; finish without waiting.
                    state_d    = err_reached ? ST_DONE : ST_WAIT_ERR;
                    rd_layer_d = '0;
                    rd_addr_d  = '0;
                end else if (rd_addr_q == last_addr) begin
                    rd_layer_d = rd_layer_q + LAYER_WIDTH'(1);
                    rd_addr_d  = '0;
                end else begin
                    rd_addr_d = rd_addr_q + 5'd1;
                end
            end
            ST_WAIT_ERR: begin
                wd_d = i_error_valid ? '0 : wd_q + WD_W'(1);
                if (err_reached) begin
                    state_d = ST_DONE;
                end else if (wd_d == WD_W'(TIMEOUT_CYCLES)) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        data_valid_d = o_data_rd_en;
        data_layer_d = o_data_rd_layer;
        data_addr_d  = o_data_rd_addr;
        exp_valid_d  = o_exp_rd_en;
        exp_addr_d   = o_exp_rd_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rd_layer_q   <= '0;
            rd_addr_q    <= '0;
            err_cnt_q    <= '0;
            wd_q         <= '0;
            data_valid_q <= 1'b0;
            data_layer_q <= '0;
            data_addr_q  <= '0;
            exp_valid_q  <= 1'b0;
            exp_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            rd_layer_q   <= rd_layer_d;
            rd_addr_q    <= rd_addr_d;
            err_cnt_q    <= err_cnt_d;
            wd_q         <= wd_d;
            data_valid_q <= data_valid_d;
            data_layer_q <= data_layer_d;
            data_addr_q  <= data_addr_d;
            exp_valid_q  <= exp_valid_d;
            exp_addr_q   <= exp_addr_d;
        end
    end

    assign o_busy          = (state_q == ST_STREAM) || (state_q == ST_WAIT_ERR);
    assign o_done          = (state_q == ST_DONE);
    assign o_timeout       = (state_q == ST_TIMEOUT);
    assign o_data_rd_en    = (state_q == ST_STREAM);
    assign o_data_rd_layer = rd_layer_q;
    assign o_data_rd_addr  = rd_addr_q;
    assign o_exp_rd_en     = o_data_rd_en && (rd_layer_q == LAYER_WIDTH'(LAYER_OUT));
    assign o_exp_rd_addr   = o_exp_rd_en ? rd_addr_q[1:0] : 2'd0;

    assign o_data_valid          = data_valid_q;
    assign o_data_layer          = data_layer_q;
    assign o_data_addr           = data_addr_q;
    assign o_data                = data_valid_q ? i_data_rd_data : '0;
    assign o_data_expected_valid = exp_valid_q;
    assign o_data_expected_addr  = exp_addr_q;
    assign o_data_expected       = exp_valid_q ? i_exp_rd_data : '0;

    bp_weight_server #(
        .DATA_WIDTH          (DATA_WIDTH),
        .LAYER_WIDTH         (LAYER_WIDTH),
        .WEIGHT_COUNTER_WIDTH(WEIGHT_COUNTER_WIDTH)
    ) u_weight_server (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_clear        (start_accept),
        .i_req_valid    (i_weight_valid_request),
        .i_req_layer    (i_weight_layer_request),
        .i_req_addr     (i_weight_addr_request),
        .o_wram_rd_en   (o_wram_rd_en),
        .o_wram_rd_layer(o_wram_rd_layer),
        .o_wram_rd_addr (o_wram_rd_addr),
        .i_wram_rd_data (i_wram_rd_data),
        .o_weight_valid (o_weight_valid),
        .o_weight_layer (o_weight_layer),
        .o_weight_addr  (o_weight_addr),
        .o_weight       (o_weight),
        .o_bad_request  (o_bad_request)
    );

endmodule

// File: tb/tb_back_propagation_scheduler.sv
// tb/tb_back_propagation_scheduler.sv - directed self-checking bench for back_propagation_scheduler
module tb_back_propagation_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        o_busy, o_done, o_timeout, o_bad_request;
    logic        o_data_rd_en;
    logic [1:0]  o_data_rd_layer;
    logic [4:0]  o_data_rd_addr;
    logic [31:0] i_data_rd_data = '0;
    logic        o_exp_rd_en;
    logic [1:0]  o_exp_rd_addr;
    logic [31:0] i_exp_rd_data = '0;
    logic        o_wram_rd_en;
    logic [1:0]  o_wram_rd_layer;
    logic [10:0] o_wram_rd_addr;
    logic [31:0] i_wram_rd_data = '0;
    logic        o_data_valid;
    logic [1:0]  o_data_layer;
    logic [4:0]  o_data_addr;
    logic [31:0] o_data;
    logic        o_data_expected_valid;
    logic [1:0]  o_data_expected_addr;
    logic [31:0] o_data_expected;
    logic        i_weight_valid_request = 1'b0;
    logic [1:0]  i_weight_layer_request = '0;
    logic [10:0] i_weight_addr_request = '0;
    logic        o_weight_valid;
    logic [1:0]  o_weight_layer;
    logic [10:0] o_weight_addr;
    logic [31:0] o_weight;
    logic        i_error_valid = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    back_propagation_scheduler dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout), .o_bad_request(o_bad_request),
        .o_data_rd_en(o_data_rd_en), .o_data_rd_layer(o_data_rd_layer), .o_data_rd_addr(o_data_rd_addr),
        .i_data_rd_data(i_data_rd_data),
        .o_exp_rd_en(o_exp_rd_en), .o_exp_rd_addr(o_exp_rd_addr), .i_exp_rd_data(i_exp_rd_data),
        .o_wram_rd_en(o_wram_rd_en), .o_wram_rd_layer(o_wram_rd_layer), .o_wram_rd_addr(o_wram_rd_addr),
        .i_wram_rd_data(i_wram_rd_data),
        .o_data_valid(o_data_valid), .o_data_layer(o_data_layer), .o_data_addr(o_data_addr), .o_data(o_data),
        .o_data_expected_valid(o_data_expected_valid), .o_data_expected_addr(o_data_expected_addr),
        .o_data_expected(o_data_expected),
        .i_weight_valid_request(i_weight_valid_request), .i_weight_layer_request(i_weight_layer_request),
        .i_weight_addr_request(i_weight_addr_request),
        .o_weight_valid(o_weight_valid), .o_weight_layer(o_weight_layer), .o_weight_addr(o_weight_addr),
        .o_weight(o_weight),
        .i_error_valid(i_error_valid)
    );

    function automatic logic [31:0] data_word(input logic [1:0] l, input logic [4:0] a);
        return 32'hDA00_0000 | (32'(l) << 8) | 32'(a);
    endfunction

    function automatic logic [31:0] exp_word(input logic [1:0] a);
        return 32'hEC00_0000 | 32'(a);
    endfunction

    function automatic logic [31:0] wram_word(input logic [1:0] l, input logic [10:0] a);
        return 32'h5E00_0000 | (32'(l) << 16) | 32'(a);
    endfunction

    // One-cycle-latency buffer and weight RAM models
    always @(posedge clk) begin
        if (o_data_rd_en) i_data_rd_data <= data_word(o_data_rd_layer, o_data_rd_addr);
        if (o_exp_rd_en)  i_exp_rd_data  <= exp_word(o_exp_rd_addr);
        if (o_wram_rd_en) i_wram_rd_data <= wram_word(o_wram_rd_layer, o_wram_rd_addr);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller raises i_start at a falling edge, then calls this.
    task automatic run_stream(input string tag);
        logic [1:0]  el;
        logic [4:0]  ea;
        logic        ev;
        logic [1:0]  eaddr;
        @(negedge clk);
        i_start = 1'b0;
        check({tag, " first read"}, {o_busy, o_data_rd_en, o_data_valid, o_bad_request, o_data_rd_layer, o_data_rd_addr},
              {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0});
        for (int i = 0; i < 69; i++) begin
            @(negedge clk);
            if (i < 2)       begin el = 2'd0; ea = 5'(i);      end
            else if (i < 34) begin el = 2'd1; ea = 5'(i - 2);  end
            else if (i < 66) begin el = 2'd2; ea = 5'(i - 34); end
            else             begin el = 2'd3; ea = 5'(i - 66); end
            ev    = (i >= 66);
            eaddr = ev ? ea[1:0] : 2'd0;
            check({tag, " stream beat"},
                  {o_data_valid, o_data_layer, o_data_addr, o_data,
                   o_data_expected_valid, o_data_expected_addr, o_data_expected},
                  {1'b1, el, ea, data_word(el, ea), ev, eaddr, ev ? exp_word(eaddr) : 32'd0});
        end
        @(negedge clk);
        check({tag, " stream end"}, {o_data_valid, o_data_expected_valid, o_data_rd_en, o_busy}, 4'b0001);
    endtask

    initial begin
        int early_done;
        int done_seen;
        int to_cyc;

        repeat (3) @(negedge clk);
        check("reset outputs",
              {o_busy, o_done, o_timeout, o_bad_request, o_data_rd_en, o_exp_rd_en, o_wram_rd_en,
               o_data_valid, o_data_expected_valid, o_weight_valid, o_data, o_weight},
              '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after reset", {o_busy, o_data_rd_en, o_data_valid, o_done, o_timeout}, '0);

        // Single weight request, layer 3 addr 98
        i_weight_valid_request = 1'b1;
        i_weight_layer_request = 2'd3;
        i_weight_addr_request  = 11'd98;
        #1;
        check("wram passthrough", {o_wram_rd_en, o_wram_rd_layer, o_wram_rd_addr}, {1'b1, 2'd3, 11'd98});
        @(negedge clk);
        i_weight_valid_request = 1'b0;
        check("weight response", {o_weight_valid, o_weight_layer, o_weight_addr, o_weight},
              {1'b1, 2'd3, 11'd98, wram_word(2'd3, 11'd98)});
        @(negedge clk);
        check("weight idle", {o_weight_valid, o_wram_rd_en}, 2'b00);

        // Back-to-back layer 2 requests 0..1055
        for (int a = 0; a <= 1056; a++) begin
            if (a > 0)
                check("weight burst", {o_weight_valid, o_weight_layer, o_weight_addr, o_weight},
                      {1'b1, 2'd2, 11'(a - 1), wram_word(2'd2, 11'(a - 1))});
            i_weight_valid_request = (a < 1056);
            i_weight_layer_request = 2'd2;
            i_weight_addr_request  = 11'(a);
            @(negedge clk);
        end
        check("weight burst end", {o_weight_valid}, 1'b0);

        // Layer 1 request is illegal
        i_weight_valid_request = 1'b1;
        i_weight_layer_request = 2'd1;
        i_weight_addr_request  = 11'd5;
        #1;
        check("bad req no ram read", {o_wram_rd_en}, 1'b0);
        @(negedge clk);
        i_weight_valid_request = 1'b0;
        check("bad req flag", {o_weight_valid, o_bad_request}, 2'b01);
        @(negedge clk);
        check("bad req sticky", {o_bad_request}, 1'b1);

        // Pass 1: full stream then 1155 errors; last error coincides with a dropped start
        i_start = 1'b1;
        run_stream("pass1");
        early_done = 0;
        for (int k = 0; k < 1154; k++) begin
            i_error_valid = 1'b1;
            @(negedge clk);
            if (o_done) early_done++;
        end
        i_error_valid = 1'b1;
        i_start = 1'b1;
        @(negedge clk);
        i_error_valid = 1'b0;
        i_start = 1'b0;
        check("no early done", 128'(early_done), 128'd0);
        check("done pulse", {o_done, o_busy, o_timeout}, 3'b100);
        @(negedge clk);
        check("done single, start dropped", {o_done, o_busy, o_data_rd_en}, 3'b000);

        // Pass 2: identical stream, then 10 errors and silence
        i_start = 1'b1;
        run_stream("pass2");
        for (int k = 0; k < 10; k++) begin
            i_error_valid = 1'b1;
            @(negedge clk);
        end
        i_error_valid = 1'b0;
        done_seen = 0;
        to_cyc = 0;
        for (int c = 1; c <= 7000; c++) begin
            @(negedge clk);
            if (o_done) done_seen++;
            if (o_timeout) begin
                to_cyc = c;
                break;
            end
        end
        check("timeout latency", 128'(to_cyc), 128'd6000);
        check("no done on timeout", 128'(done_seen), 128'd0);
        @(negedge clk);
        check("timeout single", {o_timeout, o_busy}, 2'b00);

        // Asynchronous reset mid-stream
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (19) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset outputs",
              {o_busy, o_data_rd_en, o_data_rd_layer, o_data_rd_addr, o_data_valid, o_data_layer,
               o_data_addr, o_data, o_exp_rd_en, o_done, o_timeout},
              '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after mid reset", {o_busy, o_done, o_timeout, o_data_valid}, 4'b0000);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("restart first read", {o_data_rd_en, o_data_rd_layer, o_data_rd_addr}, {1'b1, 2'd0, 5'd0});
        @(negedge clk);
        check("restart first beat", {o_data_valid, o_data_layer, o_data_addr, o_data},
              {1'b1, 2'd0, 5'd0, data_word(2'd0, 5'd0)});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
